// File: rtl/qbus_pkg.sv
// Shared types and constants for the Q-bus (MPI) cycle controller.
package qbus_pkg;

    localparam int QBUS_AW = 16;
    localparam int QBUS_DW = 16;

    // Default cycle shaping: address setup before SYNC, reply wait per phase.
    localparam int QBUS_ADDR_SETUP = 2;
    localparam int QBUS_TIMEOUT    = 64;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        SYNC,
        DATA,
        REL,
        END
    } qbus_state_t;

endpackage

// File: rtl/qbus_sync.sv
// Reply synchronizer for the asynchronous RPLY line.
// Build option: QBUS_RPLY_SYNC_EN selects a 2-flop chain (2 clocks of lag);
// without it a single sampling flop is used (1 clock of lag).
// Flops reset to 1 so the reply reads as released while in reset.
module qbus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

`ifdef QBUS_RPLY_SYNC_EN
    logic meta;

    // Two-stage chain to resolve metastability before the FSM sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
`else
    // Single sampling flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 1'b1;
        else        q <= d;
    end
`endif

endmodule

// File: rtl/qbus_cycle_ctrl.sv
// Q-bus single-word bus-cycle sequencer (DATI / DATO / DATOB).
// Sequences SYNC/DIN/DOUT against RPLY and bounds each reply wait with
// a timeout. Build option: QBUS_RPLY_SYNC_EN deepens the reply
// synchronizer (see qbus_sync); FSM behaviour is identical either way.
// The byte-write request input is named byte_op because "byte" is a
// reserved word in SystemVerilog.
module qbus_cycle_ctrl
    import qbus_pkg::*;
#(
    parameter int ADDR_SETUP = QBUS_ADDR_SETUP,
    parameter int TIMEOUT    = QBUS_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic               we,
    input  logic               byte_op,
    input  logic [QBUS_AW-1:0] addr,
    input  logic [QBUS_DW-1:0] wdata,
    output logic               ack,
    output logic               err,
    output logic [QBUS_DW-1:0] rdata,
    output logic [QBUS_DW-1:0] ad_out,
    output logic               ad_oe_n,
    input  logic [QBUS_DW-1:0] ad_in,
    output logic               sync_n,
    output logic               din_n,
    output logic               dout_n,
    output logic               wtbt_n,
    output logic               bsy_n,
    input  logic               rply_n
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = (ADDR_SETUP > 1) ? $clog2(ADDR_SETUP + 1) : 1;

    localparam logic [SW-1:0] SETUP_LAST = SW'(ADDR_SETUP - 1);
    localparam logic [CW-1:0] TCNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TCNT_MAX   = CW'(TIMEOUT);

    qbus_state_t        state, state_next;
    logic               rply_s;
    logic               we_q, byte_q, err_q;
    logic [QBUS_AW-1:0] addr_q;
    logic [QBUS_DW-1:0] wdata_q;
    logic [SW-1:0]      scnt;
    logic [CW-1:0]      tcnt;
    logic               timeout_hit;

    qbus_sync u_rply_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rply_n),
        .q     (rply_s)
    );

    // A phase times out on the edge that would take the counter to TIMEOUT;
    // a reply seen on that same edge wins.
    assign timeout_hit = (tcnt == TCNT_LAST) &&
                         (((state == DATA) && rply_s) || ((state == REL) && !rply_s));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; req is only looked at in IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (req) state_next = ADDR;
            ADDR: if (scnt == SETUP_LAST) state_next = SYNC;
            SYNC: state_next = DATA;
            DATA: begin
                if (!rply_s)          state_next = REL;
                else if (timeout_hit) state_next = END;
            end
            REL:  if (rply_s || timeout_hit) state_next = END;
            END:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Phase counters: both clear on any state change; the timeout counter
    // saturates at TIMEOUT instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= '0;
            tcnt <= '0;
        end else if (state_next != state) begin
            scnt <= '0;
            tcnt <= '0;
        end else begin
            if (state == ADDR) scnt <= scnt + SW'(1);
            if ((state == DATA || state == REL) && tcnt != TCNT_MAX)
                tcnt <= tcnt + CW'(1);
        end
    end

    // Request capture, error flag and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata   <= '0;
        end else begin
            if (state == IDLE && req) begin
                we_q    <= we;
                byte_q  <= byte_op;
                addr_q  <= addr;
                wdata_q <= wdata;
                err_q   <= 1'b0;
            end
            if (timeout_hit) err_q <= 1'b1;
            if (state == DATA && !rply_s && !we_q) rdata <= ad_in;
        end
    end

    // Pad and handshake outputs decoded from the current state.
    // NOTE: every output gets a released/inactive default first so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        sync_n  = 1'b1;
        din_n   = 1'b1;
        dout_n  = 1'b1;
        wtbt_n  = 1'b1;
        bsy_n   = 1'b1;
        ad_oe_n = 1'b1;
        ad_out  = '0;
        ack     = 1'b0;
        err     = 1'b0;
        unique case (state)
            ADDR, SYNC: begin
                ad_out  = addr_q;
                ad_oe_n = 1'b0;
                wtbt_n  = ~we_q;
                bsy_n   = 1'b0;
                sync_n  = (state == SYNC) ? 1'b0 : 1'b1;
            end
            DATA, REL: begin
                sync_n = 1'b0;
                bsy_n  = 1'b0;
                if (we_q) begin
                    ad_out  = wdata_q;
                    ad_oe_n = 1'b0;
                    wtbt_n  = ~byte_q;
                    dout_n  = (state == DATA) ? 1'b0 : 1'b1;
                end else begin
                    din_n   = (state == DATA) ? 1'b0 : 1'b1;
                end
            end
            END: begin
                ack = 1'b1;
                err = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qbus_cycle_ctrl.sv
// Bench for qbus_cycle_ctrl: per-cycle vector tables for single transfers
// plus hand-written sequences for reset-in-cycle and back-to-back requests.
// Reply lag follows the QBUS_RPLY_SYNC_EN build option.
module tb_qbus_cycle_ctrl;

`ifdef QBUS_RPLY_SYNC_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 1;
`endif

    typedef enum int {P_IDLE, P_ADDR, P_SYNC, P_DATA, P_REL, P_END} ph_t;

    typedef struct {
        logic        rply_n;
        logic [15:0] ad_in;
        ph_t         ph;
    } vec_t;

    logic        clk, rst_n, req, we, byte_op;
    logic [15:0] addr, wdata, rdata, ad_out, ad_in;
    logic        ack, err, ad_oe_n, sync_n, din_n, dout_n, wtbt_n, bsy_n, rply_n;

    vec_t vt [160];
    int   nvec;
    int   total = 0;
    int   bad   = 0;

    qbus_cycle_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .we      (we),
        .byte_op (byte_op),
        .addr    (addr),
        .wdata   (wdata),
        .ack     (ack),
        .err     (err),
        .rdata   (rdata),
        .ad_out  (ad_out),
        .ad_oe_n (ad_oe_n),
        .ad_in   (ad_in),
        .sync_n  (sync_n),
        .din_n   (din_n),
        .dout_n  (dout_n),
        .wtbt_n  (wtbt_n),
        .bsy_n   (bsy_n),
        .rply_n  (rply_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected strobe vector {sync,din,dout,wtbt,bsy,oe,ack,err} per phase.
    task automatic check_phase(input string tag, input int c, input ph_t p,
                               input logic w, input logic b,
                               input logic [15:0] a, input logic [15:0] d,
                               input logic e);
        logic [7:0]  es;
        logic [15:0] ea;
        logic        chk_ad;
        chk_ad = 1'b0;
        ea     = 16'h0;
        case (p)
            P_ADDR: begin es = {1'b1, 1'b1, 1'b1, ~w, 1'b0, 1'b0, 1'b0, 1'b0}; chk_ad = 1'b1; ea = a; end
            P_SYNC: begin es = {1'b0, 1'b1, 1'b1, ~w, 1'b0, 1'b0, 1'b0, 1'b0}; chk_ad = 1'b1; ea = a; end
            P_DATA: begin
                if (w) begin es = {1'b0, 1'b1, 1'b0, ~b, 1'b0, 1'b0, 1'b0, 1'b0}; chk_ad = 1'b1; ea = d; end
                else         es = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
            end
            P_REL: begin
                if (w) begin es = {1'b0, 1'b1, 1'b1, ~b, 1'b0, 1'b0, 1'b0, 1'b0}; chk_ad = 1'b1; ea = d; end
                else         es = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
            end
            P_END:   es = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, e};
            default: es = 8'b1111_1100;
        endcase
        check($sformatf("%s c%0d strobes{sync,din,dout,wtbt,bsy,oe,ack,err}", tag, c),
              32'({sync_n, din_n, dout_n, wtbt_n, bsy_n, ad_oe_n, ack, err}), 32'(es));
        if (chk_ad) check($sformatf("%s c%0d ad_out", tag, c), 32'(ad_out), 32'(ea));
    endtask

    task automatic init_vec(input int n);
        nvec = n;
        for (int i = 0; i < n; i++) begin
            vt[i].rply_n = 1'b1;
            vt[i].ad_in  = 16'h0;
            vt[i].ph     = P_IDLE;
        end
    endtask

    task automatic set_ph(input int from, input int to, input ph_t p);
        for (int i = from; i <= to; i++) vt[i].ph = p;
    endtask

    task automatic set_rply(input int from, input int to, input logic v, input logic [15:0] bus);
        for (int i = from; i <= to; i++) begin
            vt[i].rply_n = v;
            vt[i].ad_in  = bus;
        end
    endtask

    // Entered just after a negedge. Request is accepted on edge 0; vector c
    // drives the bus during cycle c and its outputs are sampled mid-cycle.
    // Returns just after the edge that ends the last vector's cycle.
    task automatic run_vec(input string tag, input logic w, input logic b,
                           input logic [15:0] a, input logic [15:0] d, input logic e);
        req = 1'b1; we = w; byte_op = b; addr = a; wdata = d;
        @(posedge clk);
        for (int c = 1; c < nvec; c++) begin
            #1;
            rply_n = vt[c].rply_n;
            ad_in  = vt[c].ad_in;
            @(negedge clk);
            check_phase(tag, c, vt[c].ph, w, b, a, d, e);
            if (vt[c].ph == P_END) req = 1'b0;
            @(posedge clk);
        end
    endtask

    // Standard handshake: reply asserted in cycle 5, released in cycle 8.
    task automatic fill_handshake(input logic [15:0] bus);
        init_vec(10 + LAG + 3);
        set_ph(1, 2, P_ADDR);
        set_ph(3, 3, P_SYNC);
        set_ph(4, 5 + LAG, P_DATA);
        set_ph(6 + LAG, 8 + LAG, P_REL);
        set_ph(9 + LAG, 9 + LAG, P_END);
        set_rply(5, 7, 1'b0, bus);
    endtask

    int ack_c [2];
    int acks;
    logic seen2;

    initial begin
        rst_n = 1'b1; req = 1'b0; we = 1'b0; byte_op = 1'b0;
        addr = 16'h0; wdata = 16'h0; ad_in = 16'h0; rply_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset strobes", 32'({sync_n, din_n, dout_n, wtbt_n, bsy_n, ad_oe_n, ack, err}), 32'(8'hFC));
        check("reset rdata", 32'(rdata), 32'h0);
        check("reset ad_out", 32'(ad_out), 32'h0);
        #9 rst_n = 1'b1;
        @(negedge clk);

        // Read DATI from 177560, bus returns 1234.
        fill_handshake(16'h1234);
        run_vec("read", 1'b0, 1'b0, 16'o177560, 16'h0, 1'b0);
        @(negedge clk);
        check("read rdata", 32'(rdata), 32'h1234);

        // Byte write DATOB of 00A5.
        fill_handshake(16'h0);
        run_vec("bytewr", 1'b1, 1'b1, 16'o001000, 16'h00A5, 1'b0);
        @(negedge clk);

        // Read with no reply: DIN low for exactly 64 cycles, then error.
        init_vec(68 + 4);
        set_ph(1, 2, P_ADDR);
        set_ph(3, 3, P_SYNC);
        set_ph(4, 67, P_DATA);
        set_ph(68, 68, P_END);
        run_vec("rdtmo", 1'b0, 1'b0, 16'o177562, 16'h0, 1'b1);
        @(negedge clk);
        check("rdtmo rdata kept", 32'(rdata), 32'h1234);

        // Write where RPLY never releases: REL times out.
        init_vec(70 + LAG + 4);
        set_ph(1, 2, P_ADDR);
        set_ph(3, 3, P_SYNC);
        set_ph(4, 5 + LAG, P_DATA);
        set_ph(6 + LAG, 69 + LAG, P_REL);
        set_ph(70 + LAG, 70 + LAG, P_END);
        set_rply(5, 70 + LAG, 1'b0, 16'h0);
        run_vec("reltmo", 1'b1, 1'b0, 16'o002000, 16'h5A5A, 1'b1);
        @(negedge clk);

        // Reset asserted mid-DATA releases the bus with no clock edge.
        init_vec(7);
        set_ph(1, 2, P_ADDR);
        set_ph(3, 3, P_SYNC);
        set_ph(4, 6, P_DATA);
        run_vec("prerst", 1'b0, 1'b0, 16'o004000, 16'h0, 1'b0);
        req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst strobes", 32'({sync_n, din_n, dout_n, wtbt_n, bsy_n, ad_oe_n, ack, err}), 32'(8'hFC));
        check("midrst rdata", 32'(rdata), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_handshake(16'h0);
        run_vec("postrst", 1'b1, 1'b0, 16'o004002, 16'hC3C3, 1'b0);
        @(negedge clk);

        // Held req across two writes with a bus that replies to DOUT.
        acks = 0; seen2 = 1'b0;
        ack_c[0] = 0; ack_c[1] = 0;
        req = 1'b1; we = 1'b1; byte_op = 1'b0; addr = 16'o006000; wdata = 16'h1111;
        @(posedge clk);
        for (int c = 1; c <= 60 && acks < 2; c++) begin
            #1 rply_n = din_n & dout_n;
            @(negedge clk);
            if (acks == 1 && c == ack_c[0] + 1) check("b2b gap bsy_n", 32'(bsy_n), 32'h1);
            if (acks == 1 && c == ack_c[0] + 2) check("b2b restart bsy_n", 32'(bsy_n), 32'h0);
            if (acks == 1 && !dout_n && !seen2) begin
                seen2 = 1'b1;
                check("b2b second wdata", 32'(ad_out), 32'h2222);
            end
            if (ack) begin
                check("b2b err", 32'(err), 32'h0);
                ack_c[acks] = c;
                acks++;
                wdata = 16'h2222;
                if (acks == 2) req = 1'b0;
            end
            @(posedge clk);
        end
        check("b2b ack count", 32'(acks), 32'd2);
        check("b2b ack1 cycle", 32'(ack_c[0]), 32'(6 + 2 * LAG));
        check("b2b ack2 cycle", 32'(ack_c[1]), 32'(13 + 4 * LAG));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
